// File: rtl/argmin_pkg.sv
// Shared types and helpers for the serial signed argmin reducer.
package argmin_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } argmin_state_e;

    // Index width for a frame of n samples; a single-sample frame still needs one bit.
    function automatic int argmin_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/argmin_cmp_sel.sv
// Combinational compare-select cell: keeps the running minimum or takes the candidate.
module argmin_cmp_sel #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4
) (
    input  logic             first,
    input  logic [WIDTH-1:0] cur_min,
    input  logic [IDX_W-1:0] cur_idx,
    input  logic [WIDTH-1:0] cand_data,
    input  logic [IDX_W-1:0] cand_idx,
    output logic [WIDTH-1:0] next_min,
    output logic [IDX_W-1:0] next_idx
);

    // Strict less-than keeps the earliest index on ties.
    always_comb begin
        next_min = cur_min;
        next_idx = cur_idx;
        if (first || ($signed(cand_data) < $signed(cur_min))) begin
            next_min = cand_data;
            next_idx = cand_idx;
        end else begin
            next_min = cur_min;
            next_idx = cur_idx;
        end
    end

endmodule

// File: rtl/serial_argmin_signed.sv
// Streaming signed argmin reducer over an N-beat frame with valid/ready on both sides.
// Optional framing check enabled with ARGMIN_LAST_CHECK_EN (adds in_last / frame_err).
module serial_argmin_signed
    import argmin_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N     = 16,
    localparam int IDX_W = argmin_idx_w(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
`ifdef ARGMIN_LAST_CHECK_EN
    output logic [IDX_W-1:0] out_argmin,
    input  logic             in_last,
    output logic             frame_err
`else
    output logic [IDX_W-1:0] out_argmin
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    argmin_state_e    state_r;
    argmin_state_e    state_next_s;
    logic [IDX_W-1:0] cnt_r;
    logic [WIDTH-1:0] min_r;
    logic [IDX_W-1:0] idx_r;
    logic [WIDTH-1:0] out_min_r;
    logic [IDX_W-1:0] out_argmin_r;
    logic             out_valid_r;
    logic             beat_s;
    logic             frame_end_s;
    logic             xfer_s;
    logic             ready_s;
    logic [WIDTH-1:0] next_min_s;
    logic [IDX_W-1:0] next_idx_s;

    argmin_cmp_sel #(
        .WIDTH(WIDTH),
        .IDX_W(IDX_W)
    ) u_cmp_sel (
        .first    (cnt_r == '0),
        .cur_min  (min_r),
        .cur_idx  (idx_r),
        .cand_data(in_data),
        .cand_idx (cnt_r),
        .next_min (next_min_s),
        .next_idx (next_idx_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ACCUM;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: leave ACCUM on the final beat, leave HOLD on result transfer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ACCUM: begin
                if (frame_end_s) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = ACCUM;
                end
            end
            HOLD: begin
                if (xfer_s) begin
                    state_next_s = ACCUM;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: state_next_s = ACCUM;
        endcase
    end

    // FSM outputs and handshake qualifiers; ready depends on state only.
    always_comb begin
        ready_s     = 1'b0;
        case (state_r)
            ACCUM:   ready_s = 1'b1;
            HOLD:    ready_s = 1'b0;
            default: ready_s = 1'b0;
        endcase
        beat_s      = in_valid && ready_s;
        frame_end_s = beat_s && (cnt_r == LAST_IDX);
        xfer_s      = out_valid_r && out_ready;
    end

    // Running minimum, its index and the beat counter; in_data only sampled on beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            min_r <= '0;
            idx_r <= '0;
        end else if (beat_s) begin
            cnt_r <= frame_end_s ? '0 : (cnt_r + IDX_W'(1));
            min_r <= next_min_s;
            idx_r <= next_idx_s;
        end
    end

    // Result registers: captured on the final beat, held through HOLD and beyond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_min_r    <= '0;
            out_argmin_r <= '0;
        end else if (frame_end_s) begin
            out_valid_r  <= 1'b1;
            out_min_r    <= next_min_s;
            out_argmin_r <= next_idx_s;
        end else if (xfer_s) begin
            out_valid_r  <= 1'b0;
        end
    end

`ifdef ARGMIN_LAST_CHECK_EN
    logic frame_err_r;

    // Flag any beat whose in_last disagrees with the count-based frame position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= beat_s && (in_last != (cnt_r == LAST_IDX));
        end
    end

    assign frame_err = frame_err_r;
`endif

    assign in_ready   = ready_s;
    assign out_valid  = out_valid_r;
    assign out_min    = out_min_r;
    assign out_argmin = out_argmin_r;

endmodule

// File: tb/tb_serial_argmin_signed.sv
// Directed bench with scoreboard for serial_argmin_signed (N=16, WIDTH=8).
module tb_serial_argmin_signed;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_min;
    logic [3:0] out_argmin;
`ifdef ARGMIN_LAST_CHECK_EN
    logic       in_last = 1'b0;
    logic       frame_err;
`endif

    serial_argmin_signed #(.WIDTH(8), .N(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_min   (out_min),
`ifdef ARGMIN_LAST_CHECK_EN
        .out_argmin(out_argmin),
        .in_last   (in_last),
        .frame_err (frame_err)
`else
        .out_argmin(out_argmin)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs = 0;
    int checks = 0;
    logic signed [7:0] exp_min_q[$];
    logic [3:0]        exp_idx_q[$];
    logic signed [7:0] frame_d[16];
    logic signed [7:0] mon_min;
    logic [3:0]        mon_idx;
    int acc_cyc;
    int start_cyc;
    int prev_start;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare each result on the cycle it is handed over.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_min_q.size() == 0) begin
                chk("spurious_result", 32'sd1, 32'sd0);
            end else begin
                mon_min = exp_min_q.pop_front();
                mon_idx = exp_idx_q.pop_front();
                chk("out_min", $signed(out_min), mon_min);
                chk("out_argmin", out_argmin, mon_idx);
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic last, input logic lst);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
`ifdef ARGMIN_LAST_CHECK_EN
        in_last  = lst;
`endif
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("in_ready_timeout", 32'sd0, 32'sd1);
        acc_cyc = cyc;
        @(posedge clk); #1;
        @(negedge clk);
        chk("out_valid_after_beat", out_valid, last);
`ifdef ARGMIN_LAST_CHECK_EN
        chk("frame_err", frame_err, lst != last);
`else
        if (lst !== last) chk("in_last_unused", 32'sd0, 32'sd0);
`endif
    endtask

    task automatic send_frame(input int max_gap, input int bad_k);
        logic signed [7:0] m;
        logic [3:0] mi;
        int g;
        m = frame_d[0];
        mi = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (frame_d[k] < m) begin
                m = frame_d[k];
                mi = 4'(k);
            end
        end
        exp_min_q.push_back(m);
        exp_idx_q.push_back(mi);
        for (int k = 0; k < 16; k++) begin
            send_beat(frame_d[k], k == 15, (k == 15) || (k == bad_k));
            if (k == 0) start_cyc = acc_cyc;
            if (k < 15 && max_gap > 0) begin
                g = $urandom_range(max_gap, 0);
                if (g > 0) begin
                    in_valid = 1'b0;
                    in_data  = 8'hxx;
                    repeat (g) @(negedge clk);
                end
            end
        end
        in_valid = 1'b0;
        in_data  = 8'hxx;
`ifdef ARGMIN_LAST_CHECK_EN
        in_last  = 1'b0;
`endif
    endtask

    task automatic release_result();
        int n = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        while (out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("released", out_valid, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_min", $signed(out_min), 32'sd0);
        chk("rst_out_argmin", out_argmin, 32'sd0);
        chk("rst_in_ready", in_ready, 1'b1);

        // Descending ramp: minimum at the last index.
        for (int k = 0; k < 16; k++) frame_d[k] = 8'(50 - k);
        send_frame(0, -1);
        chk("ramp_min_held", $signed(out_min), 32'sd35);
        chk("ramp_idx_held", out_argmin, 32'sd15);
        release_result();

        // Gapped random frame, then hold the result while offering a beat.
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 16; k++) frame_d[k] = 8'($urandom_range(200, 0)) - 8'sd100;
        send_frame(2, -1);
        mon_min = $signed(out_min);
        mon_idx = out_argmin;
        in_valid = 1'b1;
        in_data  = 8'h80;
        repeat (10) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_min_stable", $signed(out_min), mon_min);
            chk("hold_idx_stable", out_argmin, mon_idx);
        end
        in_valid = 1'b0;
        in_data  = 8'hxx;
        release_result();

        // Two -128 entries: earliest wins; then an all-maximum frame.
        for (int k = 0; k < 16; k++) frame_d[k] = 8'sd5;
        frame_d[7]  = -8'sd128;
        frame_d[12] = -8'sd128;
        send_frame(0, -1);
        for (int k = 0; k < 16; k++) frame_d[k] = 8'sd127;
        send_frame(0, -1);

        // Reset in the middle of a frame discards it.
        for (int k = 0; k < 9; k++) send_beat(8'(-k), 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_min", $signed(out_min), 32'sd0);
        chk("midrst_out_argmin", out_argmin, 32'sd0);
        chk("midrst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) frame_d[k] = 8'(k - 8);
        send_frame(0, -1);
        chk("post_rst_min", $signed(out_min), -32'sd8);
        chk("post_rst_idx", out_argmin, 32'sd0);

        // Back-to-back full-range frames: one frame per 17 cycles.
        prev_start = -1;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 16; k++) frame_d[k] = 8'($urandom);
            send_frame(0, -1);
            if (prev_start >= 0) chk("frame_period", start_cyc - prev_start, 32'sd17);
            prev_start = start_cyc;
        end

`ifdef ARGMIN_LAST_CHECK_EN
        // Stray in_last on beat 5 flags an error but does not end the frame.
        for (int k = 0; k < 16; k++) frame_d[k] = 8'(20 - k);
        send_frame(0, 5);
`endif

        begin
            int n = 0;
            while (exp_min_q.size() != 0 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            chk("scoreboard_drained", exp_min_q.size(), 32'sd0);
        end
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
